sync_fifo: RTL
==============

# sync_fifo

Single-clock, parametrised FIFO; next generation of the team's FIFO family, reusing its port vocabulary. Adds a first-word-fall-through (FWFT) mode, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky error flags beside the per-cycle overflow/underflow pulses. Used wherever producer and consumer share one clock domain.

## Interface
- DATA_WIDTH, 16: word width.
- FIFO_DEPTH, 32: entries; power of two, ≥4.
- ADDR_SIZE, 6: pointer width = log2(FIFO_DEPTH)+1 (includes wrap bit).
- FWFT, 0: 0 = standard read, 1 = first-word-fall-through.
- ALMOST_FULL_THRESH, 28: almost_full when count ≥ value; range 1..FIFO_DEPTH.
- ALMOST_EMPTY_THRESH, 4: almost_empty when count ≤ value; range 0..FIFO_DEPTH-1.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- write_enable  in  1  push request.
- data_in  in  DATA_WIDTH  push data.
- read_enable  in  1  pop request.
- flush  in  1  synchronous empty; storage contents untouched.
- clear_errors  in  1  clears sticky flags.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out qualifier (mode-dependent).
- fifo_full, fifo_empty  out  1 each  occupancy = FIFO_DEPTH / = 0.
- almost_full, almost_empty  out  1 each  threshold flags.
- fifo_count  out  ADDR_SIZE  occupancy 0..FIFO_DEPTH.
- fifo_overflow, fifo_underflow  out  1 each  one-cycle error pulses.
- overflow_sticky, underflow_sticky  out  1 each  latched errors.

## Operation
- Accept rules: rd_ok = read_enable & ~fifo_empty; wr_ok = write_enable & (~fifo_full | rd_ok).
- Full + read + write: both accepted, count unchanged. Empty + read + write: write accepted, read rejected.
- Rejected write: fifo_overflow pulses, word dropped, no state change. Rejected read: fifo_underflow pulses, data_out held.
- Pointers wrap modulo 2·FIFO_DEPTH; full = MSBs differ and rest equal; count = wr_ptr − rd_ptr (ADDR_SIZE bits).
- FWFT=0: accepted read loads data_out with head word next edge; data_valid high exactly that following cycle; data_out holds otherwise.
- FWFT=1: data_out = head word whenever data_valid = ~fifo_empty; read_enable pops it, next word appears after that edge.
- flush: pointers and count to 0 next edge; same-cycle read/write ignored, no error pulses; data_valid cleared; sticky flags kept.
- Sticky flags set on any pulse; clear_errors clears them; pulse in same cycle as clear_errors wins (flag stays set).
- almost_full / almost_empty combinational from registered count.

## Timing
- Reset (sync, highest priority): pointers/count 0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, data_out=0, data_valid=0, all error outputs 0. Memory array not reset.
- Write at edge N: fifo_empty/count/flags reflect it after edge N; FWFT data visible cycle after N.
- Standard read latency 1 cycle; FWFT read latency 0.
- Error pulses asserted in cycle after the offending request, for one cycle.
- Reset or flush mid-burst: in-flight request discarded; no pulse generated.

## Structure
- Shared package fifo_pkg: FIFO_MODE_STD=0, FIFO_MODE_FWFT=1, pointer-width helper constant, shared by all FIFO variants.
- One sub-module fifo_mem: DATA_WIDTH × FIFO_DEPTH dual-port array, synchronous write, asynchronous read, no reset.
- Top holds pointers, count, flag, error and output-register logic.

## Test plan
- Reset, FWFT=0: write 16'hAAAA, read next cycle -> data_out=AAAA with data_valid high one cycle; fifo_empty back to 1; count 1→0.
- Fill 32 words 0x0000..0x001F -> almost_full at count 28, fifo_full at 32; 33rd write 16'hFFFF -> fifo_overflow pulse, overflow_sticky=1, readback 0x0000..0x001F in order.
- Full, simultaneous read+write 16'h5555 -> no overflow, count stays 32, 5555 read last.
- Empty, read_enable -> fifo_underflow pulse, data_out unchanged; clear_errors -> underflow_sticky=0.
- FWFT=1: write 16'h1234 -> next cycle data_out=1234, data_valid=1 without read; read -> data_valid=0.
- 10 words loaded, flush with write_enable high -> count 0, fifo_empty=1, no pulses, next write read back correctly after pointer wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode encoding and
// the pointer-width helper used to size read/write pointers.
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width carries one extra wrap bit to tell full from empty.
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AW         = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through, occupancy count,
// threshold flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 16,
  parameter int unsigned FIFO_DEPTH          = 32,
  parameter int unsigned ADDR_SIZE           = fifo_ptr_width(FIFO_DEPTH),
  parameter int unsigned FWFT                = 0,
  parameter int unsigned ALMOST_FULL_THRESH  = 28,
  parameter int unsigned ALMOST_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic                  flush,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE-1:0]  fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky
);

  localparam int unsigned MEM_AW = ADDR_SIZE - 1;

  logic [ADDR_SIZE-1:0]  wr_ptr;
  logic [ADDR_SIZE-1:0]  rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_ok_c;
  logic                  wr_ok_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  ovf_now_c;
  logic                  udf_now_c;

  // Occupancy and flags derive from the registered pointers only.
  assign fifo_count   = wr_ptr - rd_ptr;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[ADDR_SIZE-1] != rd_ptr[ADDR_SIZE-1]) &&
                        (wr_ptr[MEM_AW-1:0] == rd_ptr[MEM_AW-1:0]);
  assign almost_full  = (fifo_count >= ADDR_SIZE'(ALMOST_FULL_THRESH));
  assign almost_empty = (fifo_count <= ADDR_SIZE'(ALMOST_EMPTY_THRESH));

  // A write into a full FIFO still lands when a read frees the head slot.
  always_comb begin
    rd_ok_c   = read_enable & ~fifo_empty;
    wr_ok_c   = write_enable & (~fifo_full | rd_ok_c);
    push_c    = wr_ok_c & ~flush & ~reset;
    pop_c     = rd_ok_c & ~flush & ~reset;
    ovf_now_c = write_enable & ~wr_ok_c & ~flush;
    udf_now_c = read_enable & ~rd_ok_c & ~flush;
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_c),
    .waddr (wr_ptr[MEM_AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[MEM_AW-1:0]),
    .rdata (head)
  );

  // Pointers, error pulses and sticky flags; a pulse visible alongside
  // clear_errors keeps its sticky flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_overflow    <= 1'b0;
      fifo_underflow   <= 1'b0;
      overflow_sticky  <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
        if (pop_c)  rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      fifo_overflow    <= ovf_now_c;
      fifo_underflow   <= udf_now_c;
      overflow_sticky  <= ovf_now_c | fifo_overflow |
                          (overflow_sticky & ~clear_errors);
      underflow_sticky <= udf_now_c | fifo_underflow |
                          (underflow_sticky & ~clear_errors);
    end
  end

  if (FWFT == 32'(FIFO_MODE_FWFT)) begin : g_fwft
    // Head word is presented directly; zero while nothing is stored.
    assign data_valid = ~fifo_empty;
    assign data_out   = fifo_empty ? '0 : head;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= pop_c;
        if (pop_c) dout_q <= head;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end

endmodule : sync_fifo
